// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry pipeline register (main + skid) with flush, NOP insertion and stall counting.
// All state advances on the falling edge of clk, in step with the neighbouring pipe registers.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_count
);

  localparam int unsigned STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                main_valid_q, main_valid_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic                skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q, in_ready_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic                accept, drain;

  // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;

  // Next-state: main ctrl is zeroed whenever main goes invalid, so out_ctrl is a NOP then.
  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    stall_d      = stall_q;

    if (main_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end

    if (flush) begin
      state_d      = ST_EMPTY;
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d      = ST_FULL;
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (drain) begin
            state_d      = ST_EMPTY;
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d      = ST_ONE;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            skid_data_d  = '0;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end
      endcase
    end

    in_ready_d = (state_d != ST_FULL);
  end

  // State registers; reset outranks flush by construction.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_ctrl    = main_ctrl_q;
  assign out_data    = main_data_q;
  assign occupancy   = 2'(state_q);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (falling-edge design).
module tb_pipe_stage_elastic;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset, in_valid, flush, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_count;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one active (falling) edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("rst_out_valid", DATA_W'(out_valid), 0);
    chk("rst_out_ctrl", DATA_W'(out_ctrl), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", DATA_W'(occupancy), 0);
    chk("rst_stall", DATA_W'(stall_count), 0);
    chk("rst_in_ready", DATA_W'(in_ready), 1);
    reset = 1'b0;

    // Streaming 1..8 with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(16'h0100 + i), DATA_W'(i), 1'b1, 1'b0);
      tick();
      chk("stream_valid", DATA_W'(out_valid), 1);
      chk("stream_data", out_data, DATA_W'(i));
      chk("stream_ctrl", DATA_W'(out_ctrl), DATA_W'(16'h0100 + i));
      chk("stream_occ", DATA_W'(occupancy), 1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_end_valid", DATA_W'(out_valid), 0);
    chk("stream_end_ctrl", DATA_W'(out_ctrl), 0);
    chk("stream_stall", DATA_W'(stall_count), 0);

    // Backpressure: A then B with out_ready low
    drive(1'b1, 16'h00AA, 128'hA, 1'b0, 1'b0);
    tick();
    chk("bp_a_occ", DATA_W'(occupancy), 1);
    drive(1'b1, 16'h00BB, 128'hB, 1'b0, 1'b0);
    tick();
    chk("bp_full_occ", DATA_W'(occupancy), 2);
    chk("bp_full_ready", DATA_W'(in_ready), 0);
    chk("bp_full_data", out_data, 128'hA);
    chk("bp_stall1", DATA_W'(stall_count), 1);
    drive(1'b1, 16'h00CC, 128'hC, 1'b0, 1'b0);
    tick();
    chk("bp_hold_data", out_data, 128'hA);
    chk("bp_hold_ctrl", DATA_W'(out_ctrl), 16'h00AA);
    chk("bp_hold_occ", DATA_W'(occupancy), 2);
    chk("bp_stall2", DATA_W'(stall_count), 2);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("bp_b_data", out_data, 128'hB);
    chk("bp_b_ctrl", DATA_W'(out_ctrl), 16'h00BB);
    chk("bp_b_occ", DATA_W'(occupancy), 1);
    chk("bp_b_ready", DATA_W'(in_ready), 1);
    tick();
    chk("bp_drained_valid", DATA_W'(out_valid), 0);
    chk("bp_stall_final", DATA_W'(stall_count), 2);

    // Flush while FULL with C presented
    drive(1'b1, 16'h00AA, 128'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00BB, 128'hB, 1'b0, 1'b0);
    tick();
    chk("fl_pre_occ", DATA_W'(occupancy), 2);
    drive(1'b1, 16'h00CC, 128'hC, 1'b0, 1'b1);
    tick();
    chk("fl_valid", DATA_W'(out_valid), 0);
    chk("fl_ctrl", DATA_W'(out_ctrl), 0);
    chk("fl_occ", DATA_W'(occupancy), 0);
    chk("fl_ready", DATA_W'(in_ready), 1);
    chk("fl_stall", DATA_W'(stall_count), 4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("fl_no_c", DATA_W'(out_valid), 0);

    // Bubble with unknown payload
    drive(1'b0, 'x, 'x, 1'b0, 1'b0);
    tick();
    tick();
    chk("bub_valid", DATA_W'(out_valid), 0);
    chk("bub_ctrl", DATA_W'(out_ctrl), 0);
    chk("bub_occ", DATA_W'(occupancy), 0);

    // Flush in ONE with same-cycle accept and drain
    drive(1'b1, 16'h00DD, 128'hD, 1'b1, 1'b0);
    tick();
    chk("fl1_d_data", out_data, 128'hD);
    drive(1'b1, 16'h00EE, 128'hE, 1'b1, 1'b1);
    tick();
    chk("fl1_occ", DATA_W'(occupancy), 0);
    chk("fl1_ctrl", DATA_W'(out_ctrl), 0);
    chk("fl1_stall", DATA_W'(stall_count), 4);

    // Reset outranks flush while FULL
    drive(1'b1, 16'h00AA, 128'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00BB, 128'hB, 1'b0, 1'b0);
    tick();
    chk("rp_pre_stall", DATA_W'(stall_count), 5);
    reset = 1'b1;
    drive(1'b1, 16'h00CC, 128'hC, 1'b0, 1'b1);
    tick();
    chk("rp_valid", DATA_W'(out_valid), 0);
    chk("rp_ctrl", DATA_W'(out_ctrl), 0);
    chk("rp_data", out_data, 0);
    chk("rp_occ", DATA_W'(occupancy), 0);
    chk("rp_stall", DATA_W'(stall_count), 0);
    chk("rp_ready", DATA_W'(in_ready), 1);
    reset = 1'b0;

    // Saturation: hold one instruction stalled for 70000 edges
    drive(1'b1, 16'h0055, 128'h55, 1'b0, 1'b0);
    tick();
    drive(1'b0, 'x, 'x, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", DATA_W'(stall_count), 16'hFFFE);
    tick();
    chk("sat_ffff", DATA_W'(stall_count), 16'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    chk("sat_hold", DATA_W'(stall_count), 16'hFFFF);
    chk("sat_data_stable", out_data, 128'h55);
    chk("sat_ctrl_stable", DATA_W'(out_ctrl), 16'h0055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter CTRL_W, default 16: width of the control bundle (Jump, RegDst, Branch, Mem*, RegWrite, ALUOperation, ...).
REQ-002 Parameter DATA_W, default 128: width of the data bundle (ReadData1/2, immediate, PC+4, register fields, shamt).
REQ-003 clk  input  1: single clock; all state updates on the falling edge of clk, matching the other pipe registers.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the falling edge of clk.
REQ-005 in_valid  input  1: upstream stage presents a valid instruction.
REQ-006 in_ready  output  1: block can accept an instruction this cycle.
REQ-007 in_ctrl  input  CTRL_W: upstream control bundle.
REQ-008 in_data  input  DATA_W: upstream data bundle.
REQ-009 flush  input  1: discard all held and incoming instructions (branch/jump squash).
REQ-010 out_valid  output  1: downstream stage sees a valid instruction.
REQ-011 out_ready  input  1: downstream stage consumes the instruction this cycle.
REQ-012 out_ctrl  output  CTRL_W: held control bundle; all-zero (NOP) whenever out_valid=0.
REQ-013 out_data  output  DATA_W: held data bundle.
REQ-014 occupancy  output  2: number of held instructions, 0..2.
REQ-015 stall_count  output  16: saturating count of downstream-stall cycles.

Function
REQ-016 Storage SHALL be two entries, main and skid, each holding valid, ctrl and data; order SHALL be strictly FIFO.
REQ-017 States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1); occupancy SHALL equal 0/1/2 respectively.
REQ-018 in_ready SHALL be 1 exactly when skid is empty, with no combinational path from out_ready to in_ready.
REQ-019 accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated at the same falling edge.
REQ-020 out_valid = main.valid; out_data = main.data; out_ctrl = main.ctrl when main.valid, else zero.
REQ-021 EMPTY: accept -> ONE with main <= input; otherwise hold.
REQ-022 ONE: accept & drain -> ONE with main <= input; accept only -> FULL with skid <= input; drain only -> EMPTY; neither -> hold.
REQ-023 FULL: no accept is possible; drain -> ONE with main <= skid and skid cleared; otherwise hold.
REQ-024 Latency SHALL be one falling edge from accept in EMPTY to out_valid=1; throughput SHALL be one instruction per cycle while out_ready=1.
REQ-025 Held entries SHALL remain bit-stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL force EMPTY at the next edge, discarding a same-cycle accept; a same-cycle drain counts as completed.
REQ-027 flush SHALL have priority over accept and drain; reset SHALL have priority over flush.
REQ-028 in_ctrl/in_data SHALL be ignored when in_valid=0; X values there SHALL NOT reach out_ctrl.
REQ-029 stall_count SHALL increment at each edge with out_valid=1 and out_ready=0, saturate at 0xFFFF, and be unaffected by flush.

Reset
REQ-030 On reset: state EMPTY, both entries' ctrl and data = 0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0, in_ready=1 from the next cycle.
REQ-031 Reset mid-operation SHALL drop all held instructions with no partial output.

Verification
REQ-032 Streaming: out_ready=1, in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 in order, each one edge later, occupancy stays 1.
REQ-033 Backpressure: load A, B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A stable; raise out_ready -> A then B out, stall_count counts held cycles.
REQ-034 Flush: FULL with A, B, in_valid=1 carrying C, flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, C never appears.
REQ-035 Bubble: in_valid=0 with in_ctrl=X and in_data=X -> out_ctrl=0, out_valid=0, no X on outputs.
REQ-036 Saturation: out_valid=1, out_ready=0 held for 70000 cycles -> stall_count=0xFFFF and remains there.
REQ-037 Reset priority: reset=1 and flush=1 while FULL -> all outputs at reset values and stall_count=0.
